obi_wb_bridge: RTL and testbench

- Joins the core's two OBI master ports (instruction fetch, data load/store) onto the single Wishbone-classic master port of the Controller (core_cyc/stb/we/addr/data/ack).
- Arbitrates round-robin between the ports and allows one outstanding transaction in the whole bridge.
- The Wishbone bus has no byte-select, so partial-byte stores become read-modify-write (RMW) sequences.
- A bounded-wait timeout prevents a missing ack from hanging the core.

---
 rtl/obi_wb_pkg.sv | 36 +++
 rtl/obi_wb_rr_arbiter.sv | 35 +++
 rtl/obi_wb_bridge.sv | 182 ++++++++++++++++++
 tb/tb_obi_wb_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI-to-Wishbone bridge.
// Holds the bridge state encoding, the requester port ids and the byte-merge helper.
package obi_wb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RMW_RD,
      MERGE,
      RMW_WR,
      RESP
   } bridge_state_e;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   localparam logic [3:0] BE_FULL = 4'hF;

   // Enabled bytes come from the new word; all other bytes keep the word read from the bus.
   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/obi_wb_rr_arbiter.sv
// Two-way round-robin arbiter between the instruction and data OBI ports.
// Grants are one-hot and combinational; the last-grant pointer moves only on an issued grant.
module obi_wb_rr_arbiter
   import obi_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   port_e last_q;

   // On a tie the port that was not served last wins; reset leaves data favoured.
   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req == 2'b11) begin
            gnt = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT_INSTR;
      end else if (|gnt) begin
         last_q <= gnt[1] ? PORT_DATA : PORT_INSTR;
      end
   end

endmodule

// File: rtl/obi_wb_bridge.sv
// Bridges the core's instruction and data OBI ports onto one Wishbone-classic master.
// One transaction in flight; partial stores become read-modify-write; a stalled bus times out.
module obi_wb_bridge
   import obi_wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    instr_req_i,
   output logic                    instr_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,

   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,

   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_addr_o,
   output logic [DATA_WIDTH-1:0]   wb_data_o,
   input  logic [DATA_WIDTH-1:0]   wb_data_i,
   input  logic                    wb_ack_i,

   output logic                    timeout_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   bridge_state_e state_q, state_d;

   port_e                  port_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [3:0]             be_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [DATA_WIDTH-1:0]  word_q;
   logic [DATA_WIDTH-1:0]  instr_rdata_q;
   logic [DATA_WIDTH-1:0]  data_rdata_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   timeout_q;

   logic [1:0]             gnt;
   logic                   accept;
   logic                   sel_we;
   logic                   stb_active;
   logic                   tmo_hit;
   logic                   enter_resp;
   port_e                  resp_port;
   logic [DATA_WIDTH-1:0]  resp_word;

   obi_wb_rr_arbiter u_arbiter (
      .clk    (clk),
      .rst    (rst),
      .enable ((state_q == IDLE) && !rst),
      .req    ({data_req_i, instr_req_i}),
      .gnt    (gnt)
   );

   assign accept      = (state_q == IDLE) && (|gnt);
   assign sel_we      = gnt[1] & data_we_i;
   assign instr_gnt_o = gnt[0];
   assign data_gnt_o  = gnt[1];

   assign stb_active = (state_q == RD) || (state_q == WR) ||
                       (state_q == RMW_RD) || (state_q == RMW_WR);

   // An ack in the final allowed cycle still wins over the abort.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && stb_active && !wb_ack_i &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!sel_we) begin
                  state_d = RD;
               end else if (data_be_i == BE_FULL) begin
                  state_d = WR;
               end else if (data_be_i == 4'h0) begin
                  state_d = RESP;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD, WR, RMW_WR: begin
            if (wb_ack_i || tmo_hit) begin
               state_d = RESP;
            end
         end
         RMW_RD: begin
            if (wb_ack_i) begin
               state_d = MERGE;
            end else if (tmo_hit) begin
               state_d = RESP;
            end
         end
         MERGE:   state_d = RMW_WR;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Only a completed plain read returns bus data; writes, empty stores and aborts return zero.
   assign enter_resp = (state_d == RESP) && (state_q != RESP);
   assign resp_port  = (state_q == IDLE) ? (gnt[1] ? PORT_DATA : PORT_INSTR) : port_q;
   assign resp_word  = ((state_q == RD) && wb_ack_i) ? wb_data_i : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= (stb_active && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
         timeout_q <= tmo_hit;
      end
   end

   // Request fields are captured once at grant; later requester activity is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port_q  <= PORT_INSTR;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         if (accept) begin
            port_q  <= gnt[1] ? PORT_DATA : PORT_INSTR;
            addr_q  <= gnt[1] ? data_addr_i : instr_addr_i;
            be_q    <= gnt[1] ? data_be_i : BE_FULL;
            wdata_q <= data_wdata_i;
         end
         if ((state_q == RMW_RD) && wb_ack_i) begin
            word_q <= wb_data_i;
         end
         if (state_q == MERGE) begin
            wdata_q <= be_merge(word_q, wdata_q, be_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else if (enter_resp) begin
         if (resp_port == PORT_DATA) begin
            data_rdata_q <= resp_word;
         end else begin
            instr_rdata_q <= resp_word;
         end
      end
   end

   assign wb_stb_o  = stb_active;
   assign wb_cyc_o  = stb_active || (state_q == MERGE);
   assign wb_we_o   = (state_q == WR) || (state_q == RMW_WR);
   assign wb_addr_o = addr_q & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   assign wb_data_o = wb_we_o ? wdata_q : '0;
   assign timeout_o = timeout_q;

   assign instr_rvalid_o = (state_q == RESP) && (port_q == PORT_INSTR);
   assign data_rvalid_o  = (state_q == RESP) && (port_q == PORT_DATA);
   assign instr_rdata_o  = instr_rdata_q;
   assign data_rdata_o   = data_rdata_q;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge: a small Wishbone memory slave plus hand-computed checks.
module tb_obi_wb_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, timeout_o;
   logic [31:0] wb_addr_o, wb_data_o, wb_data_i;

   logic        slave_en;
   logic        load_mem;
   logic [31:0] mem [0:255];
   int          rd_cnt, wr_cnt;
   int          total, bad;
   int          rd0, wr0;
   logic        exp_data;

   always #5 clk = ~clk;

   obi_wb_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_addr_i   (instr_addr_i),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_gnt_o     (data_gnt_o),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_we_o        (wb_we_o),
      .wb_addr_o      (wb_addr_o),
      .wb_data_o      (wb_data_o),
      .wb_data_i      (wb_data_i),
      .wb_ack_i       (wb_ack_i),
      .timeout_o      (timeout_o)
   );

   // Zero-wait slave: acks in the same cycle as stb whenever slave_en is set.
   assign wb_ack_i  = wb_stb_o & slave_en;
   assign wb_data_i = mem[wb_addr_o[9:2]];

   always_ff @(posedge clk) begin
      if (load_mem) begin
         mem[64]  <= 32'h0000_0013;
         mem[129] <= 32'h1122_3344;
         rd_cnt   <= 0;
         wr_cnt   <= 0;
      end else if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
         if (wb_we_o) begin
            mem[wb_addr_o[9:2]] <= wb_data_o;
            wr_cnt <= wr_cnt + 1;
         end else begin
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic is_data, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (is_data) begin
         data_req_i   = 1'b1;
         data_we_i    = we;
         data_be_i    = be;
         data_addr_i  = addr;
         data_wdata_i = wdata;
      end else begin
         instr_req_i  = 1'b1;
         instr_addr_i = addr;
      end
   endtask

   task automatic releaseReq();
      instr_req_i  = 1'b0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'hFFFF_FFFF;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      releaseReq();
      instr_addr_i = 32'h100;
      instr_req_i  = 1'b1;
      slave_en     = 1'b1;
      load_mem     = 1'b1;
      #2 rst = 1'b1;
      #1;
      checkBit("rst_cyc", wb_cyc_o, 1'b0);
      checkBit("rst_stb", wb_stb_o, 1'b0);
      checkBit("rst_instr_gnt", instr_gnt_o, 1'b0);
      checkBit("rst_instr_rvalid", instr_rvalid_o, 1'b0);
      checkBit("rst_timeout", timeout_o, 1'b0);
      checkOutput("rst_instr_rdata", instr_rdata_o, 32'h0);
      checkOutput("rst_data_rdata", data_rdata_o, 32'h0);
      step();
      load_mem    = 1'b0;
      instr_req_i = 1'b0;
      step();
      rst = 1'b0;
      step();

      $display("[TB] single instruction read");
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
      #1;
      checkBit("t1_instr_gnt", instr_gnt_o, 1'b1);
      checkBit("t1_data_gnt", data_gnt_o, 1'b0);
      step();
      releaseReq();
      checkBit("t1_cyc", wb_cyc_o, 1'b1);
      checkBit("t1_stb", wb_stb_o, 1'b1);
      checkBit("t1_we", wb_we_o, 1'b0);
      checkOutput("t1_addr", wb_addr_o, 32'h100);
      step();
      checkBit("t1_rvalid", instr_rvalid_o, 1'b1);
      checkBit("t1_data_rvalid", data_rvalid_o, 1'b0);
      checkOutput("t1_rdata", instr_rdata_o, 32'h13);
      checkBit("t1_cyc_resp", wb_cyc_o, 1'b0);
      step();
      checkBit("t1_rvalid_drop", instr_rvalid_o, 1'b0);
      checkOutput("t1_rdata_hold", instr_rdata_o, 32'h13);

      $display("[TB] round-robin with both ports requesting");
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h204, 32'h0);
      for (int k = 0; k < 4; k++) begin
         exp_data = (k % 2 == 0);
         #1;
         checkBit("t2_data_gnt", data_gnt_o, exp_data);
         checkBit("t2_instr_gnt", instr_gnt_o, !exp_data);
         step();
         checkOutput("t2_addr", wb_addr_o, exp_data ? 32'h204 : 32'h100);
         step();
         checkBit("t2_data_rvalid", data_rvalid_o, exp_data);
         checkBit("t2_instr_rvalid", instr_rvalid_o, !exp_data);
         checkBit("t2_no_gnt_resp", data_gnt_o | instr_gnt_o, 1'b0);
         if (exp_data) begin
            checkOutput("t2_data_rdata", data_rdata_o, 32'h1122_3344);
         end else begin
            checkOutput("t2_instr_rdata", instr_rdata_o, 32'h13);
         end
         if (k == 3) releaseReq();
         step();
      end

      $display("[TB] partial store read-modify-write");
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      applyStimulus(1'b1, 1'b1, 4'b0010, 32'h204, 32'h0000_AB00);
      #1;
      checkBit("t3_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      checkBit("t3_rd_stb", wb_stb_o, 1'b1);
      checkBit("t3_rd_we", wb_we_o, 1'b0);
      checkOutput("t3_rd_addr", wb_addr_o, 32'h204);
      step();
      checkBit("t3_merge_cyc", wb_cyc_o, 1'b1);
      checkBit("t3_merge_stb", wb_stb_o, 1'b0);
      step();
      checkBit("t3_wr_stb", wb_stb_o, 1'b1);
      checkBit("t3_wr_we", wb_we_o, 1'b1);
      checkOutput("t3_wr_addr", wb_addr_o, 32'h204);
      checkOutput("t3_wr_data", wb_data_o, 32'h1122_AB44);
      step();
      checkBit("t3_rvalid", data_rvalid_o, 1'b1);
      checkOutput("t3_rdata", data_rdata_o, 32'h0);
      checkOutput("t3_reads", 32'(rd_cnt - rd0), 32'd1);
      checkOutput("t3_writes", 32'(wr_cnt - wr0), 32'd1);
      checkOutput("t3_mem", mem[129], 32'h1122_AB44);
      step();

      $display("[TB] full-word write then read back");
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h300, 32'hDEAD_BEEF);
      #1;
      checkBit("t4_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      checkBit("t4_we", wb_we_o, 1'b1);
      checkOutput("t4_addr", wb_addr_o, 32'h300);
      checkOutput("t4_data", wb_data_o, 32'hDEAD_BEEF);
      step();
      checkBit("t4_rvalid", data_rvalid_o, 1'b1);
      checkOutput("t4_reads", 32'(rd_cnt - rd0), 32'd0);
      checkOutput("t4_writes", 32'(wr_cnt - wr0), 32'd1);
      step();
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
      #1;
      checkBit("t4_rd_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      step();
      checkBit("t4_rd_rvalid", data_rvalid_o, 1'b1);
      checkOutput("t4_rd_rdata", data_rdata_o, 32'hDEAD_BEEF);
      step();

      $display("[TB] store with no byte enables");
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h204, 32'h1234_5678);
      #1;
      checkBit("t5_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      checkBit("t5_cyc", wb_cyc_o, 1'b0);
      checkBit("t5_rvalid", data_rvalid_o, 1'b1);
      checkOutput("t5_rdata", data_rdata_o, 32'h0);
      step();
      checkOutput("t5_mem", mem[129], 32'h1122_AB44);

      $display("[TB] timeout with a silent slave");
      slave_en = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
      #1;
      checkBit("t6_gnt", instr_gnt_o, 1'b1);
      step();
      releaseReq();
      for (int i = 0; i < 8; i++) begin
         checkBit("t6_stb_held", wb_stb_o, 1'b1);
         step();
      end
      checkBit("t6_cyc_drop", wb_cyc_o, 1'b0);
      checkBit("t6_timeout", timeout_o, 1'b1);
      checkBit("t6_rvalid", instr_rvalid_o, 1'b1);
      checkOutput("t6_rdata", instr_rdata_o, 32'h0);
      step();
      checkBit("t6_timeout_pulse", timeout_o, 1'b0);
      slave_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
      #1;
      checkBit("t6_next_gnt", instr_gnt_o, 1'b1);
      step();
      releaseReq();
      step();
      checkBit("t6_next_rvalid", instr_rvalid_o, 1'b1);
      checkOutput("t6_next_rdata", instr_rdata_o, 32'h13);
      step();

      $display("[TB] reset during read-modify-write write phase");
      applyStimulus(1'b1, 1'b1, 4'b0001, 32'h204, 32'h0000_00AA);
      #1;
      checkBit("t7_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      step();
      step();
      checkBit("t7_wr_we", wb_we_o, 1'b1);
      checkOutput("t7_wr_data", wb_data_o, 32'h1122_ABAA);
      rst = 1'b1;
      #1;
      checkBit("t7_rst_cyc", wb_cyc_o, 1'b0);
      checkBit("t7_rst_stb", wb_stb_o, 1'b0);
      step();
      rst = 1'b0;
      step();
      checkBit("t7_no_data_rvalid", data_rvalid_o, 1'b0);
      checkBit("t7_no_instr_rvalid", instr_rvalid_o, 1'b0);
      checkOutput("t7_mem_kept", mem[129], 32'h1122_AB44);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h204, 32'h0);
      #1;
      checkBit("t7_next_gnt", data_gnt_o, 1'b1);
      step();
      releaseReq();
      step();
      checkBit("t7_next_rvalid", data_rvalid_o, 1'b1);
      checkOutput("t7_next_rdata", data_rdata_o, 32'h1122_AB44);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
